// File: rtl/moka_rv32_trace_pkg.sv
// Shared types for the RV32I retirement-trace buffer.
//
// Contents:
//   TRACE_XLEN     width of the PC, instruction and result fields
//   TRACE_RD_W     width of the destination-register field
//   trace_state_e  capture FSM encoding (IDLE/ARMED/POST/DONE)
//   trace_entry_t  one stored trace entry
//
// Optional feature macro: MOKA_RV32_TRACE_HAZARD_EN adds a 4-bit hazard field
// {StallF, StallD, FlushD, FlushE} to every entry.
package moka_rv32_trace_pkg;

  localparam int TRACE_XLEN = 32;
  localparam int TRACE_RD_W = 5;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_ARMED = 2'd1,
    TS_POST  = 2'd2,
    TS_DONE  = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] instr;
    logic [TRACE_RD_W-1:0] rd;
    logic [TRACE_XLEN-1:0] result;
`ifdef MOKA_RV32_TRACE_HAZARD_EN
    logic [3:0]            hazard;
`endif
  } trace_entry_t;

endpackage

// File: rtl/moka_rv32_trace_ram.sv
// Trace storage: DEPTH entries of trace_entry_t.
// One synchronous write port, one asynchronous (combinational) read port.
// The array has no reset; its contents are only read after being written.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   wAddr  in   write address
//   wData  in   entry to write
//   rAddr  in   read address
//   rData  out  entry at rAddr (combinational)
module moka_rv32_trace_ram
  import moka_rv32_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  trace_entry_t  wData,
  input  logic [AW-1:0] rAddr,
  output trace_entry_t  rData
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/moka_rv32_trace_buffer.sv
// Retirement-trace capture for the pipelined RV32I core, placed beside WB.
// Committed instructions {PC, instr, Rd, result} are written into a circular
// buffer while ARMED; a PC match triggers, a configurable number of further
// commits is captured (POST), then the buffer is streamed out oldest-first
// on a valid/ready interface (DONE) and the block returns to IDLE.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   arm_i                          clear buffer and enter ARMED (highest priority)
//   trig_pc_i                      PC that fires the trigger
//   post_cnt_i                     commits captured after the trigger entry
//   commit_*_i                     WB retirement record
//   rd_ready_i / rd_valid_o        readout handshake (DONE only)
//   rd_pc_o, rd_instr_o,
//   rd_rd_o, rd_result_o           readout entry fields
//   state_o                        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count_o                        entries currently held
//   overflow_o                     sticky: an entry was overwritten since arm
//
// Optional feature macro: MOKA_RV32_TRACE_HAZARD_EN adds stall_f_i, stall_d_i,
// flush_d_i, flush_e_i and rd_hazard_o = {StallF, StallD, FlushD, FlushE}.
module moka_rv32_trace_buffer
  import moka_rv32_trace_pkg::*;
#(
  parameter  int DATA_WIDTH = TRACE_XLEN,
  parameter  int DEPTH      = 16,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic [DATA_WIDTH-1:0] trig_pc_i,
  input  logic [CNT_W-1:0]      post_cnt_i,
  input  logic                  commit_valid_i,
  input  logic [DATA_WIDTH-1:0] commit_pc_i,
  input  logic [DATA_WIDTH-1:0] commit_instr_i,
  input  logic [4:0]            commit_rd_i,
  input  logic [DATA_WIDTH-1:0] commit_result_i,
`ifdef MOKA_RV32_TRACE_HAZARD_EN
  input  logic                  stall_f_i,
  input  logic                  stall_d_i,
  input  logic                  flush_d_i,
  input  logic                  flush_e_i,
  output logic [3:0]            rd_hazard_o,
`endif
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_pc_o,
  output logic [DATA_WIDTH-1:0] rd_instr_o,
  output logic [4:0]            rd_rd_o,
  output logic [DATA_WIDTH-1:0] rd_result_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  // Largest post count that still leaves the trigger entry in the buffer.
  localparam logic [CNT_W-1:0] POST_MAX = CNT_W'(DEPTH - 1);

  // The entry layout is fixed by the package, so the data width must match it.
  if (DATA_WIDTH != TRACE_XLEN) begin : gWidthCheck
    $error("DATA_WIDTH must equal TRACE_XLEN");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
    $error("DEPTH must be a power of two >= 2");
  end

  trace_state_e     state, stateNext;
  logic [AW-1:0]    wp, wpNext;
  logic [CNT_W-1:0] count, countNext;
  logic [CNT_W-1:0] postCnt, postCntNext;
  logic             overflow, overflowNext;

  logic             memWe;
  logic [AW-1:0]    rp;
  logic [CNT_W-1:0] postLoad;
  logic             pcMatch;
  trace_entry_t     wEntry;
  trace_entry_t     rEntry;

  assign postLoad = (post_cnt_i > POST_MAX) ? POST_MAX : post_cnt_i;
  assign pcMatch  = (commit_pc_i == trig_pc_i);
  // Oldest entry sits count slots behind wp; a full buffer wraps back onto wp.
  assign rp       = wp - count[AW-1:0];

  always_comb begin
    wEntry        = '0;
    wEntry.pc     = commit_pc_i;
    wEntry.instr  = commit_instr_i;
    wEntry.rd     = commit_rd_i;
    wEntry.result = commit_result_i;
`ifdef MOKA_RV32_TRACE_HAZARD_EN
    wEntry.hazard = {stall_f_i, stall_d_i, flush_d_i, flush_e_i};
`endif
  end

  moka_rv32_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uRam (
    .clk   (clk),
    .we    (memWe),
    .wAddr (wp),
    .wData (wEntry),
    .rAddr (rp),
    .rData (rEntry)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TS_IDLE;
      wp       <= '0;
      count    <= '0;
      postCnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      wp       <= wpNext;
      count    <= countNext;
      postCnt  <= postCntNext;
      overflow <= overflowNext;
    end
  end

  // Next-state and output logic
  always_comb begin
    stateNext    = state;
    wpNext       = wp;
    countNext    = count;
    postCntNext  = postCnt;
    overflowNext = overflow;
    memWe        = 1'b0;
    rd_valid_o   = 1'b0;

    if (arm_i) begin
      // Re-arming wins over any same-cycle commit, trigger or pop.
      stateNext    = TS_ARMED;
      wpNext       = '0;
      countNext    = '0;
      overflowNext = 1'b0;
    end else begin
      case (state)
        TS_IDLE: begin
        end

        TS_ARMED: begin
          if (commit_valid_i) begin
            memWe  = 1'b1;
            wpNext = wp + AW'(1);
            if (count == CNT_FULL) begin
              overflowNext = 1'b1;
            end else begin
              countNext = count + CNT_W'(1);
            end
            if (pcMatch) begin
              postCntNext = postLoad;
              stateNext   = (postLoad == '0) ? TS_DONE : TS_POST;
            end
          end
        end

        TS_POST: begin
          // postCnt is at least 1 in this state.
          if (commit_valid_i) begin
            memWe       = 1'b1;
            wpNext      = wp + AW'(1);
            postCntNext = postCnt - CNT_W'(1);
            if (count == CNT_FULL) begin
              overflowNext = 1'b1;
            end else begin
              countNext = count + CNT_W'(1);
            end
            if (postCnt == CNT_W'(1)) begin
              stateNext = TS_DONE;
            end
          end
        end

        TS_DONE: begin
          rd_valid_o = (count != '0);
          if (rd_valid_o && rd_ready_i) begin
            countNext = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              stateNext = TS_IDLE;
            end
          end
        end

        default: begin
          stateNext = TS_IDLE;
        end
      endcase
    end
  end

  assign rd_pc_o     = rEntry.pc;
  assign rd_instr_o  = rEntry.instr;
  assign rd_rd_o     = rEntry.rd;
  assign rd_result_o = rEntry.result;
`ifdef MOKA_RV32_TRACE_HAZARD_EN
  assign rd_hazard_o = rEntry.hazard;
`endif

  assign state_o    = state;
  assign count_o    = count;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_moka_rv32_trace_buffer.sv
module tb_moka_rv32_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [3:0]  hz;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             arm;
  logic [DW-1:0]    trigPc;
  logic [CNT_W-1:0] postCnt;
  logic             cValid;
  logic [DW-1:0]    cPc, cInstr, cResult;
  logic [4:0]       cRd;
  logic             stallF, stallD, flushD, flushE;
  logic             rdReady;
  logic             rdValid;
  logic [DW-1:0]    rdPc, rdInstr, rdResult;
  logic [4:0]       rdRd;
  logic [3:0]       rdHazard;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int   checks = 0;
  int   passes = 0;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  moka_rv32_trace_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .arm_i           (arm),
    .trig_pc_i       (trigPc),
    .post_cnt_i      (postCnt),
    .commit_valid_i  (cValid),
    .commit_pc_i     (cPc),
    .commit_instr_i  (cInstr),
    .commit_rd_i     (cRd),
    .commit_result_i (cResult),
`ifdef MOKA_RV32_TRACE_HAZARD_EN
    .stall_f_i       (stallF),
    .stall_d_i       (stallD),
    .flush_d_i       (flushD),
    .flush_e_i       (flushE),
    .rd_hazard_o     (rdHazard),
`endif
    .rd_ready_i      (rdReady),
    .rd_valid_o      (rdValid),
    .rd_pc_o         (rdPc),
    .rd_instr_o      (rdInstr),
    .rd_rd_o         (rdRd),
    .rd_result_o     (rdResult),
    .state_o         (state),
    .count_o         (count),
    .overflow_o      (overflow)
  );

`ifndef MOKA_RV32_TRACE_HAZARD_EN
  assign rdHazard = 4'b0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mkEntry(input logic [31:0] pc, input logic [3:0] hz);
    exp_t e;
    e.pc     = pc;
    e.instr  = {16'hC0DE, pc[15:0]};
    e.rd     = pc[6:2];
    e.result = ~pc;
    e.hz     = hz;
    return e;
  endfunction

  // One retiring instruction; fields derived from the PC so each entry is unique.
  task automatic commit(input logic [31:0] pc, input logic [3:0] hz);
    exp_t e;
    e = mkEntry(pc, hz);
    cValid  = 1'b1;
    cPc     = e.pc;
    cInstr  = e.instr;
    cRd     = e.rd;
    cResult = e.result;
    {stallF, stallD, flushD, flushE} = hz;
    @(posedge clk); #1;
    cValid = 1'b0;
    {stallF, stallD, flushD, flushE} = 4'b0000;
  endtask

  task automatic doArm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // Consume entries until the DUT returns to IDLE; toggle gives ready 1,0,1,...
  task automatic drain(input bit toggle, input int budget);
    int n = 0;
    while (state != 2'd0 && n < budget) begin
      rdReady = toggle ? ((n % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    rdReady = 1'b0;
    chk("drain_reached_idle", state, 0);
    chk("drain_all_entries_seen", sbQ.size(), 0);
    chk("drain_count_zero", count, 0);
  endtask

  // Scoreboard monitor: every accepted readout beat must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rdValid && rdReady) begin
        if (sbQ.size() == 0) begin
          chk("unexpected_readout_pc", rdPc, 32'hxxxxxxxx);
        end else begin
          e = sbQ.pop_front();
          chk("rd_pc", rdPc, e.pc);
          chk("rd_instr", rdInstr, e.instr);
          chk("rd_rd", 32'(rdRd), 32'(e.rd));
          chk("rd_result", rdResult, e.result);
`ifdef MOKA_RV32_TRACE_HAZARD_EN
          chk("rd_hazard", 32'(rdHazard), 32'(e.hz));
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; trigPc = '0; postCnt = '0;
    cValid = 1'b0; cPc = '0; cInstr = '0; cRd = '0; cResult = '0;
    stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    rdReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_rd_valid", rdValid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Commits in IDLE are ignored.
    commit(32'h0, 4'h0);
    chk("idle_ignores_commit", count, 0);

    // Basic capture: trigger at 0x10, two post commits.
    trigPc = 32'h10; postCnt = 5'd2;
    doArm();
    chk("armed_state", state, 1);
    for (int i = 0; i < 7; i++) begin
      commit(32'(i * 4), 4'h0);
      if (i == 0) chk("count_after_first_commit", count, 1);
      if (i == 4) chk("post_after_trigger", state, 2);
      sbQ.push_back(mkEntry(32'(i * 4), 4'h0));
    end
    chk("basic_done", state, 3);
    chk("basic_count", count, 7);
    chk("basic_no_overflow", overflow, 0);
    drain(1'b0, 20);

    // Wrap: 20 commits into 16 slots, trigger on the last with no post.
    trigPc = 32'h4C; postCnt = 5'd0;
    doArm();
    for (int i = 0; i < 20; i++) begin
      commit(32'(i * 4), 4'h0);
      if (i >= 4) sbQ.push_back(mkEntry(32'(i * 4), 4'h0));
    end
    chk("wrap_done", state, 3);
    chk("wrap_overflow", overflow, 1);
    chk("wrap_count", count, 16);
    drain(1'b0, 30);

    // Post count 31 clamps to 15; toggled ready during readout.
    trigPc = 32'h100; postCnt = 5'd31;
    doArm();
    commit(32'h100, 4'h0);
    sbQ.push_back(mkEntry(32'h100, 4'h0));
    for (int i = 1; i <= 15; i++) begin
      commit(32'h100 + 32'(i * 4), 4'h0);
      sbQ.push_back(mkEntry(32'h100 + 32'(i * 4), 4'h0));
      if (i == 14) chk("clamp_still_post", state, 2);
    end
    chk("clamp_done", state, 3);
    chk("clamp_count", count, 16);
    chk("clamp_no_overflow", overflow, 0);
    drain(1'b1, 60);

    // arm during readout abandons it.
    trigPc = 32'h200; postCnt = 5'd0;
    doArm();
    commit(32'h1F8, 4'h0);
    commit(32'h1FC, 4'h0);
    commit(32'h200, 4'h0);
    chk("abort_done", state, 3);
    sbQ.push_back(mkEntry(32'h1F8, 4'h0));
    sbQ.push_back(mkEntry(32'h1FC, 4'h0));
    sbQ.push_back(mkEntry(32'h200, 4'h0));
    rdReady = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort_count_before_arm", count, 1);
    rdReady = 1'b0;
    arm = 1'b1;
    sbQ.delete();
    @(posedge clk); #1;
    arm = 1'b0;
    chk("abort_rd_valid", rdValid, 0);
    chk("abort_state_armed", state, 1);
    chk("abort_count", count, 0);

    // Same-cycle arm and commit: the commit is dropped.
    arm = 1'b1;
    commit(32'h300, 4'h0);
    arm = 1'b0;
    chk("arm_commit_count", count, 0);
    chk("arm_commit_state", state, 1);

    // Hazard flags travel with the entry (FlushE only).
    trigPc = 32'h304; postCnt = 5'd0;
    commit(32'h304, 4'b0001);
    sbQ.push_back(mkEntry(32'h304, 4'b0001));
    chk("hazard_done", state, 3);
    chk("hazard_count", count, 1);
    drain(1'b0, 10);

    // Asynchronous reset in the middle of POST.
    trigPc = 32'h400; postCnt = 5'd5;
    doArm();
    commit(32'h400, 4'h0);
    commit(32'h404, 4'h0);
    chk("pre_reset_post", state, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_state", state, 0);
    chk("async_reset_count", count, 0);
    chk("async_reset_overflow", overflow, 0);
    chk("async_reset_rd_valid", rdValid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
